// File: rtl/moore_gen_pkg.sv
// Shared state encoding, default parameters and width helper for the serial
// Moore pattern generator.
package moore_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int DEF_REP_W      = 4;

  // ceil(log2(n)), never less than 1 so counters always have at least one bit
  function automatic int clog2w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/moore_seq_gen_piso_shift_reg.sv
// Parallel-in serial-out shift register: load wins over shift, shifts left
// with zero fill, MSB is the serial output.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb
);

  logic [WIDTH-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (en) begin
      if (load)       shreg_d = load_data;
      else if (shift) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) shreg_q <= '0;
    else      shreg_q <= shreg_d;
  end

  assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/moore_seq_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated
// in_repeat extra times with an idle gap between copies. Outputs decode from state only.
module moore_seq_gen
  import moore_gen_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int REP_W      = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [REP_W-1:0] in_repeat,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW         = clog2w(WIDTH);
  localparam int GW         = clog2w(GAP_CYCLES + 1);
  localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_LOAD_I);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             sr_load, sr_shift, sr_msb;
  logic [WIDTH-1:0] sr_load_data;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;
    sr_load_data = hold_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            hold_d       = in_data;
            sr_load      = 1'b1;
            sr_load_data = in_data;
            rep_cnt_d    = in_repeat;
            bit_cnt_d    = BIT_LOAD;
            state_d      = SEND;
          end
        end
        SEND: begin
          sr_shift = 1'b1;
          if (bit_cnt_q == '0) begin
            if (rep_cnt_q == '0) begin
              state_d = DONE;
            end else begin
              rep_cnt_d = rep_cnt_q - REP_W'(1);
              if (GAP_CYCLES > 0) begin
                state_d   = GAP;
                gap_cnt_d = GAP_LOAD;
              end else begin
                // back-to-back repeat: reload takes priority over the shift
                sr_load   = 1'b1;
                bit_cnt_d = BIT_LOAD;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q - BW'(1);
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            state_d   = SEND;
            sr_load   = 1'b1;
            bit_cnt_d = BIT_LOAD;
          end else begin
            gap_cnt_d = gap_cnt_q - GW'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (sr_load),
    .shift     (sr_shift),
    .load_data (sr_load_data),
    .msb       (sr_msb)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SEND);
  assign out       = (state_q == SEND) & sr_msb;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_moore_seq_gen.sv
// Scoreboard bench: two generators (gap 2 and gap 0) share stimulus; each has
// a queue of expected per-cycle output tokens built from the pattern rules.
module tb_moore_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [3:0] in_repeat = '0;

  logic a_ready, a_out, a_valid, a_busy, a_done;
  logic b_ready, b_out, b_valid, b_busy, b_done;

  int checks = 0;
  int failures = 0;
  int en_mode = 0;

  // token = {in_ready, out_valid, out, busy, done}
  localparam logic [4:0] IDLE_T = 5'b10000;
  localparam logic [4:0] GAP_T  = 5'b00010;
  localparam logic [4:0] DONE_T = 5'b00011;

  logic [4:0] q_a[$];
  logic [4:0] q_b[$];
  logic [4:0] cur_a = IDLE_T;
  logic [4:0] cur_b = IDLE_T;
  bit         prev_en = 1'b0;

  moore_seq_gen #(.WIDTH(8), .GAP_CYCLES(2), .REP_W(4)) dut_g2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_repeat(in_repeat), .in_ready(a_ready), .out(a_out), .out_valid(a_valid),
    .busy(a_busy), .done(a_done)
  );

  moore_seq_gen #(.WIDTH(8), .GAP_CYCLES(0), .REP_W(4)) dut_g0 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_repeat(in_repeat), .in_ready(b_ready), .out(b_out), .out_valid(b_valid),
    .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t rdy/vld/out/busy/done got=%b expected=%b", name, $time, act, exp);
    end
  endtask

  // Expected frame: (rep+1) copies MSB-first, gap idle cycles between copies, one DONE cycle.
  task automatic push_frame(input bit which, input logic [7:0] d, input int rep);
    int gap;
    logic [4:0] tok;
    gap = which ? 0 : 2;
    for (int r = 0; r <= rep; r++) begin
      for (int b = 7; b >= 0; b--) begin
        tok = {2'b01, d[b], 2'b10};
        if (which) q_b.push_back(tok); else q_a.push_back(tok);
      end
      if (r < rep)
        for (int g = 0; g < gap; g++)
          if (which) q_b.push_back(GAP_T); else q_a.push_back(GAP_T);
    end
    if (which) q_b.push_back(DONE_T); else q_a.push_back(DONE_T);
  endtask

  // Monitor: the state only advances across an edge that saw en=1 and rst high.
  always @(negedge clk) begin
    if (!rst) begin
      q_a.delete();
      q_b.delete();
      cur_a = IDLE_T;
      cur_b = IDLE_T;
    end else if (prev_en) begin
      cur_a = (q_a.size() > 0) ? q_a.pop_front() : IDLE_T;
      cur_b = (q_b.size() > 0) ? q_b.pop_front() : IDLE_T;
    end
    check("gap2", {a_ready, a_valid, a_out, a_busy, a_done}, cur_a);
    check("gap0", {b_ready, b_valid, b_out, b_busy, b_done}, cur_b);
    if (rst && en && in_valid) begin
      if (cur_a == IDLE_T && q_a.size() == 0) push_frame(1'b0, in_data, int'(in_repeat));
      if (cur_b == IDLE_T && q_b.size() == 0) push_frame(1'b1, in_data, int'(in_repeat));
    end
    prev_en = rst && en;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (en_mode)
        0:       en = 1'b1;
        1:       en = ~en;
        default: en = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (!(cur_a == IDLE_T && cur_b == IDLE_T && q_a.size() == 0 && q_b.size() == 0)
           && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= limit) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout t=%0t limit=%0d q_a=%0d q_b=%0d", $time, limit, q_a.size(), q_b.size());
    end
  endtask

  task automatic issue(input logic [7:0] d, input logic [3:0] rep);
    int n;
    @(posedge clk);
    #1;
    in_data   = d;
    in_repeat = rep;
    in_valid  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!en && n < 50);
    if (!en) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout t=%0t en never high", $time);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run(input logic [7:0] d, input logic [3:0] rep, input int mode,
                     input bit pulse, input logic [7:0] pulse_data);
    en_mode = mode;
    wait_idle(60);
    issue(d, rep);
    if (pulse) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      @(negedge clk);
      #1;
      if (q_a.size() > 3 && q_b.size() > 3) begin
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = pulse_data;
        in_repeat = 4'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
    wait_idle(800);
  endtask

  task automatic reset_abort();
    en_mode = 0;
    wait_idle(60);
    issue(8'h81, 4'd1);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_gap2", {a_ready, a_valid, a_out, a_busy, a_done}, IDLE_T);
    check("abort_gap0", {b_ready, b_valid, b_out, b_busy, b_done}, IDLE_T);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    run(8'hB4, 4'd0, 0, 1'b0, 8'h00);
    run(8'hF0, 4'd2, 0, 1'b0, 8'h00);
    run(8'hA5, 4'd1, 0, 1'b0, 8'h00);
    run(8'hC3, 4'd0, 1, 1'b0, 8'h00);
    run(8'h81, 4'd0, 0, 1'b1, 8'hFF);
    reset_abort();
    run(8'h5A, 4'd15, 0, 1'b1, 8'hFF);
    for (int i = 0; i < 20; i++)
      run(8'($urandom), 4'($urandom_range(0, 3)), $urandom_range(0, 2), 1'($urandom), 8'($urandom));
    en_mode = 0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
